// File: rtl/plcp_pkg.sv
// Shared types and constants for the PLCP header parser: FSM states, header layout, CRC-16-CCITT step.
package plcp_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      REPORT  = 2'd2
   } state_t;

   localparam int          HDR_BITS   = 48;
   localparam logic [15:0] CRC_POLY   = 16'h1021;
   localparam logic [15:0] CRC_PRESET = 16'hFFFF;
   localparam logic [7:0]  SIGNAL_1M  = 8'h0A;

   // Bit offsets within the header stream, bit 0 = first bit after SFD.
   localparam int SIG_OFS = 0;
   localparam int SVC_OFS = 8;
   localparam int LEN_OFS = 16;
   localparam int CRC_OFS = 32;

   typedef struct packed {
      logic [15:0] len;
      logic [7:0]  svc;
      logic [7:0]  sig;
   } hdr_t;

   function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic din);
      crc16_next = {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/plcp_header_parser_if.sv
// Bit-stream input and header-report output bundle of the PLCP header parser.
interface plcp_header_parser_if;
   logic        data_bit;
   logic        data_valid;
   logic        sfd_detected;
   logic [7:0]  signal_field;
   logic [7:0]  service_field;
   logic [15:0] length_field;
   logic        header_valid;
   logic        header_error;
   logic        busy;

   modport slave (
      input  data_bit, data_valid, sfd_detected,
      output signal_field, service_field, length_field, header_valid, header_error, busy
   );

   modport master (
      output data_bit, data_valid, sfd_detected,
      input  signal_field, service_field, length_field, header_valid, header_error, busy
   );
endinterface

// File: rtl/plcp_crc16.sv
// Serial CRC-16-CCITT register; init presets and may coincide with en (first bit folds into the preset).
module plcp_crc16
   import plcp_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        init,
   input  logic        en,
   input  logic        din,
   output logic [15:0] crc
);

   logic [15:0] crc_q;
   logic [15:0] crc_d;
   logic [15:0] base;

   always_comb begin
      base  = init ? CRC_PRESET : crc_q;
      crc_d = en ? crc16_next(base, din) : base;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         crc_q <= CRC_PRESET;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/plcp_header_parser.sv
// Collects the 48-bit PLCP header after SFD; verdict pulse one cycle after bit 47; no backpressure.
// PLCP_SIGNAL_CHECK_EN additionally rejects any SIGNAL other than 1 Mbps.
module plcp_header_parser
   import plcp_pkg::*;
#(
   parameter int GAP_LIMIT = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   plcp_header_parser_if.slave  bus
);

   localparam int GAP_W = $clog2(GAP_LIMIT + 1);

   state_t             state_q, state_d;
   logic [5:0]         bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic [31:0]        hdr_sr_q, hdr_sr_d;
   logic [14:0]        rx_crc_q, rx_crc_d;
   hdr_t               fld_q, fld_d;
   logic               header_valid_q, header_valid_d;
   logic               header_error_q, header_error_d;
   logic               busy_q, busy_d;

   logic               crc_init;
   logic               crc_en;
   logic [15:0]        crc_val;
   logic               capture;
   logic [5:0]         bit_idx;
   logic               crc_ok;
   logic               len_ok;
   logic               sig_ok;

   plcp_crc16 u_crc (
      .clk   (clk),
      .reset (reset),
      .init  (crc_init),
      .en    (crc_en),
      .din   (bus.data_bit),
      .crc   (crc_val)
   );

   // Verdict inputs are only consumed in the cycle that carries bit 47.
   always_comb begin
      crc_ok = ({rx_crc_q, bus.data_bit} == ~crc_val);
      len_ok = |hdr_sr_q[LEN_OFS +: 16];
`ifdef PLCP_SIGNAL_CHECK_EN
      sig_ok = (hdr_sr_q[SIG_OFS +: 8] == SIGNAL_1M);
`else
      sig_ok = 1'b1;
`endif
   end

   always_comb begin
      state_d        = state_q;
      bit_cnt_d      = bit_cnt_q;
      gap_cnt_d      = gap_cnt_q;
      hdr_sr_d       = hdr_sr_q;
      rx_crc_d       = rx_crc_q;
      fld_d          = fld_q;
      header_valid_d = 1'b0;
      header_error_d = 1'b0;
      crc_init       = 1'b0;
      crc_en         = 1'b0;
      capture        = 1'b0;
      bit_idx        = bit_cnt_q;

      // SFD restarts collection from any state; a coincident strobe is bit 0.
      if (bus.sfd_detected) begin
         state_d   = COLLECT;
         bit_cnt_d = 6'd0;
         gap_cnt_d = '0;
         hdr_sr_d  = '0;
         crc_init  = 1'b1;
         bit_idx   = 6'd0;
         capture   = bus.data_valid;
      end else begin
         case (state_q)
            COLLECT: begin
               if (bus.data_valid) begin
                  capture   = 1'b1;
                  gap_cnt_d = '0;
                  if (bit_cnt_q == 6'(HDR_BITS - 1)) begin
                     state_d        = REPORT;
                     fld_d.sig      = hdr_sr_q[SIG_OFS +: 8];
                     fld_d.svc      = hdr_sr_q[SVC_OFS +: 8];
                     fld_d.len      = hdr_sr_q[LEN_OFS +: 16];
                     header_valid_d = crc_ok & len_ok & sig_ok;
                     header_error_d = ~(crc_ok & len_ok & sig_ok);
                  end
               end else if (gap_cnt_q == GAP_W'(GAP_LIMIT - 1)) begin
                  state_d        = IDLE;
                  header_error_d = 1'b1;
               end else begin
                  gap_cnt_d = gap_cnt_q + GAP_W'(1);
               end
            end
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      if (capture) begin
         bit_cnt_d = bit_idx + 6'd1;
         if (bit_idx < 6'(CRC_OFS)) begin
            hdr_sr_d[bit_idx[4:0]] = bus.data_bit;
            crc_en                 = 1'b1;
         end else begin
            rx_crc_d = {rx_crc_q[13:0], bus.data_bit};
         end
      end

      busy_d = (state_d == COLLECT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         bit_cnt_q      <= '0;
         gap_cnt_q      <= '0;
         hdr_sr_q       <= '0;
         rx_crc_q       <= '0;
         fld_q          <= '0;
         header_valid_q <= 1'b0;
         header_error_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         gap_cnt_q      <= gap_cnt_d;
         hdr_sr_q       <= hdr_sr_d;
         rx_crc_q       <= rx_crc_d;
         fld_q          <= fld_d;
         header_valid_q <= header_valid_d;
         header_error_q <= header_error_d;
         busy_q         <= busy_d;
      end
   end

   assign bus.signal_field  = fld_q.sig;
   assign bus.service_field = fld_q.svc;
   assign bus.length_field  = fld_q.len;
   assign bus.header_valid  = header_valid_q;
   assign bus.header_error  = header_error_q;
   assign bus.busy          = busy_q;

endmodule
